// File: rtl/wb_mem_arbiter_if.sv
// Line-wide Wishbone link shared by the CPU instruction/data ports and the memory port.
// The master modport drives the request side; the slave modport returns data/ack/rty.
interface wb_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] dat_m;
  logic [DATA_W-1:0] dat_s;
  logic              ack;
  logic              rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, rty
  );
endinterface

// File: rtl/wb_mem_arbiter.sv
// Round-robin merge of the CPU instruction and data Wishbone ports onto one line-wide memory port.
// Optional macro ARB_TIMEOUT_EN adds a BUSY watchdog that turns a stalled memory cycle into a retry.
module wb_mem_arbiter #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_mem_arbiter_if.slave  imem_if,
  wb_mem_arbiter_if.slave  dmem_if,
  wb_mem_arbiter_if.master mem_if
);
  localparam int unsigned SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_RETRY} state_e;
  typedef enum logic {GNT_IMEM = 1'b0, GNT_DMEM = 1'b1} gnt_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat;
  } mem_req_t;

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              last_q, last_d;
  mem_req_t          req_q, req_d;
  logic              mem_cyc_q, mem_cyc_d;
  logic [DATA_W-1:0] imem_dat_q, imem_dat_d;
  logic [DATA_W-1:0] dmem_dat_q, dmem_dat_d;
  logic              imem_ack_q, imem_ack_d;
  logic              imem_rty_q, imem_rty_d;
  logic              dmem_ack_q, dmem_ack_d;
  logic              dmem_rty_q, dmem_rty_d;

  logic imem_req_c;
  logic dmem_req_c;
  logic imem_wins_c;
  logic gnt_cyc_c;
  logic tmo_hit_c;
  logic unused_c;

  assign imem_req_c  = imem_if.cyc & imem_if.stb;
  assign dmem_req_c  = dmem_if.cyc & dmem_if.stb;
  // On a tie the port that was not served last wins.
  assign imem_wins_c = imem_req_c & (~dmem_req_c | (last_q == GNT_DMEM));
  assign gnt_cyc_c   = (gnt_q == GNT_IMEM) ? imem_if.cyc : dmem_if.cyc;

  // The instruction port is read-only, so its write-side fields are ignored.
  assign unused_c = ^{imem_if.we, imem_if.sel, imem_if.dat_m};

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TMO_W    = (TMO_BITS > 8) ? TMO_BITS : 8;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit_c = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cleared while idle so every BUSY phase starts counting from zero.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_IDLE) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_BUSY) && !mem_if.ack && !mem_if.rty) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int unsigned UNUSED_TMO = TIMEOUT_CYCLES;

  assign tmo_hit_c = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; ack takes priority over rty and the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (imem_req_c || dmem_req_c) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (mem_if.ack) begin
          state_d = S_RESP;
        end else if (mem_if.rty || tmo_hit_c) begin
          state_d = S_RETRY;
        end
      end
      S_RESP, S_RETRY: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next values of all registered outputs and grant bookkeeping.
  always_comb begin
    gnt_d      = gnt_q;
    last_d     = last_q;
    req_d      = req_q;
    mem_cyc_d  = mem_cyc_q;
    imem_dat_d = imem_dat_q;
    dmem_dat_d = dmem_dat_q;
    imem_ack_d = 1'b0;
    imem_rty_d = 1'b0;
    dmem_ack_d = 1'b0;
    dmem_rty_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (imem_req_c || dmem_req_c) begin
          mem_cyc_d = 1'b1;
          if (imem_wins_c) begin
            gnt_d     = GNT_IMEM;
            req_d.we  = 1'b0;
            req_d.adr = imem_if.adr;
            req_d.sel = '1;
            req_d.dat = '0;
          end else begin
            gnt_d     = GNT_DMEM;
            req_d.we  = dmem_if.we;
            req_d.adr = dmem_if.adr;
            req_d.sel = dmem_if.sel;
            req_d.dat = dmem_if.dat_m;
          end
        end
      end
      S_BUSY: begin
        if (mem_if.ack) begin
          mem_cyc_d = 1'b0;
          if (gnt_q == GNT_IMEM) begin
            imem_dat_d = mem_if.dat_s;
            imem_ack_d = gnt_cyc_c;
          end else begin
            dmem_dat_d = mem_if.dat_s;
            dmem_ack_d = gnt_cyc_c;
          end
        end else if (mem_if.rty || tmo_hit_c) begin
          mem_cyc_d = 1'b0;
          if (gnt_q == GNT_IMEM) begin
            imem_rty_d = gnt_cyc_c;
          end else begin
            dmem_rty_d = gnt_cyc_c;
          end
        end
      end
      S_RESP, S_RETRY: begin
        last_d = gnt_q;
      end
      default: begin
        mem_cyc_d = 1'b0;
      end
    endcase
  end

  // Datapath and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= GNT_IMEM;
      last_q     <= GNT_DMEM;
      req_q      <= '0;
      mem_cyc_q  <= 1'b0;
      imem_dat_q <= '0;
      dmem_dat_q <= '0;
      imem_ack_q <= 1'b0;
      imem_rty_q <= 1'b0;
      dmem_ack_q <= 1'b0;
      dmem_rty_q <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      req_q      <= req_d;
      mem_cyc_q  <= mem_cyc_d;
      imem_dat_q <= imem_dat_d;
      dmem_dat_q <= dmem_dat_d;
      imem_ack_q <= imem_ack_d;
      imem_rty_q <= imem_rty_d;
      dmem_ack_q <= dmem_ack_d;
      dmem_rty_q <= dmem_rty_d;
    end
  end

  assign mem_if.cyc   = mem_cyc_q;
  assign mem_if.stb   = mem_cyc_q;
  assign mem_if.we    = req_q.we;
  assign mem_if.adr   = req_q.adr;
  assign mem_if.sel   = req_q.sel;
  assign mem_if.dat_m = req_q.dat;

  assign imem_if.dat_s = imem_dat_q;
  assign imem_if.ack   = imem_ack_q;
  assign imem_if.rty   = imem_rty_q;

  assign dmem_if.dat_s = dmem_dat_q;
  assign dmem_if.ack   = dmem_ack_q;
  assign dmem_if.rty   = dmem_rty_q;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed self-checking bench for wb_mem_arbiter with a small scripted memory model.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_wb_mem_arbiter;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned SEL_W  = DATA_W / 8;
  localparam int unsigned TMO    = 8;

  typedef enum int {M_ACK, M_RTY, M_BOTH, M_SILENT} mmode_e;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem_if ();
  wb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dmem_if ();
  wb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  wb_mem_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .imem_if(imem_if),
    .dmem_if(dmem_if),
    .mem_if (mem_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: responds after mem_delay wait cycles; read data encodes the address unless fixed.
  mmode_e            mem_mode   = M_ACK;
  int                mem_delay  = 0;
  int                mem_wait   = 0;
  int                mem_done   = 0;
  bit                use_fixed  = 1'b0;
  logic [DATA_W-1:0] fixed_rdata = '0;

  always @(negedge clk) begin
    mem_if.ack   = 1'b0;
    mem_if.rty   = 1'b0;
    mem_if.dat_s = use_fixed ? fixed_rdata : {8{4'h0, mem_if.adr}};
    if (rst_n && mem_if.cyc && mem_if.stb && mem_mode != M_SILENT) begin
      if (mem_wait >= mem_delay) begin
        mem_if.ack = (mem_mode != M_RTY);
        mem_if.rty = (mem_mode != M_ACK);
        mem_wait   = 0;
        mem_done++;
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end
  end

  // Upstream response monitor.
  int i_acks = 0, d_acks = 0, i_rtys = 0, d_rtys = 0, overlap = 0;

  always @(negedge clk) begin
    if (imem_if.ack) i_acks++;
    if (dmem_if.ack) d_acks++;
    if (imem_if.rty) i_rtys++;
    if (dmem_if.rty) d_rtys++;
    if ((imem_if.ack || imem_if.rty) && (dmem_if.ack || dmem_if.rty)) overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_i(input bit on, input logic [ADDR_W-1:0] adr);
    imem_if.cyc = on;
    imem_if.stb = on;
    imem_if.adr = adr;
  endtask

  task automatic set_d(input bit on, input bit we, input logic [ADDR_W-1:0] adr,
                       input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] dat);
    dmem_if.cyc   = on;
    dmem_if.stb   = on;
    dmem_if.we    = we;
    dmem_if.adr   = adr;
    dmem_if.sel   = sel;
    dmem_if.dat_m = dat;
  endtask

  task automatic wait_pulse(input string tag, input bit is_d, input bit is_rty, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (is_d) seen = is_rty ? dmem_if.rty : dmem_if.ack;
      else      seen = is_rty ? imem_if.rty : imem_if.ack;
    end
    check_eq(tag, DATA_W'(seen), DATA_W'(1));
  endtask

  // Both ports request; report which one is acked first (0 = imem, 1 = dmem), then release both.
  task automatic first_winner(input string tag, input int exp_who);
    int who = -1;
    for (int n = 0; n < 20 && who < 0; n++) begin
      tick();
      if (imem_if.ack)      who = 0;
      else if (dmem_if.ack) who = 1;
    end
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0, '0);
    check_eq(tag, DATA_W'(who), DATA_W'(exp_who));
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int seq[4];
    int got;
    int base_a, base_b, base_c;
    logic [DATA_W-1:0] wdat;

    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0, '0);
    imem_if.we    = 1'b0;
    imem_if.sel   = '0;
    imem_if.dat_m = '0;

    // Reset values.
    #1;
    check_eq("rst_mem_cyc", DATA_W'(mem_if.cyc), '0);
    do_reset();
    check_eq("rst_imem_ack", DATA_W'(imem_if.ack), '0);
    check_eq("rst_dmem_dat", dmem_if.dat_s, '0);

    // Instruction read, minimum latency.
    use_fixed   = 1'b1;
    fixed_rdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    set_i(1'b1, 12'h010);
    tick();
    check_eq("i_rd_stb", DATA_W'(mem_if.stb), DATA_W'(1));
    check_eq("i_rd_adr", DATA_W'(mem_if.adr), DATA_W'(12'h010));
    check_eq("i_rd_we", DATA_W'(mem_if.we), '0);
    check_eq("i_rd_sel", DATA_W'(mem_if.sel), DATA_W'(16'hFFFF));
    check_eq("i_rd_early_ack", DATA_W'(imem_if.ack), '0);
    tick();
    check_eq("i_rd_ack", DATA_W'(imem_if.ack), DATA_W'(1));
    check_eq("i_rd_dat", imem_if.dat_s, 128'h0123456789ABCDEF0123456789ABCDEF);
    check_eq("i_rd_no_dack", DATA_W'(dmem_if.ack), '0);
    set_i(1'b0, '0);
    tick();
    check_eq("i_rd_ack_1cyc", DATA_W'(imem_if.ack), '0);
    check_eq("i_rd_cyc_drop", DATA_W'(mem_if.cyc), '0);
    use_fixed = 1'b0;

    // Data write with a slow memory.
    mem_delay = 2;
    base_a    = d_acks;
    wdat      = 128'h11111111_0000BEEF_33333333_44444444;
    set_d(1'b1, 1'b1, 12'hABC, 16'h0030, wdat);
    tick();
    check_eq("d_wr_we", DATA_W'(mem_if.we), DATA_W'(1));
    check_eq("d_wr_adr", DATA_W'(mem_if.adr), DATA_W'(12'hABC));
    check_eq("d_wr_sel", DATA_W'(mem_if.sel), DATA_W'(16'h0030));
    check_eq("d_wr_dat", mem_if.dat_m, wdat);
    wait_pulse("d_wr_ack", 1'b1, 1'b0, 10);
    set_d(1'b0, 1'b0, '0, '0, '0);
    tick();
    check_eq("d_wr_ack_1cyc", DATA_W'(dmem_if.ack), '0);
    check_eq("d_wr_ack_count", DATA_W'(d_acks - base_a), DATA_W'(1));
    check_eq("d_wr_capture", dmem_if.dat_s, {8{16'h0ABC}});
    mem_delay = 0;

    // Both ports request continuously from reset: grants alternate I, D, I, D.
    do_reset();
    got = 0;
    set_i(1'b1, 12'h100);
    set_d(1'b1, 1'b0, 12'h200, '1, '0);
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick();
      if (imem_if.ack) begin
        seq[got] = 0;
        got++;
      end else if (dmem_if.ack) begin
        seq[got] = 1;
        got++;
      end
    end
    set_i(1'b0, '0);
    set_d(1'b0, 1'b0, '0, '0, '0);
    tick();
    check_eq("alt_count", DATA_W'(got), DATA_W'(4));
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("alt_order_%0d", k), DATA_W'(seq[k]), DATA_W'(k % 2));
    end
    check_eq("alt_i_dat", imem_if.dat_s, {8{16'h0100}});
    check_eq("alt_d_dat", dmem_if.dat_s, {8{16'h0200}});

    // Memory retry on a data read.
    mem_mode = M_RTY;
    base_a   = d_acks;
    base_b   = d_rtys;
    set_d(1'b1, 1'b0, 12'h321, '1, '0);
    wait_pulse("d_rty_seen", 1'b1, 1'b1, 10);
    check_eq("d_rty_no_ack", DATA_W'(dmem_if.ack), '0);
    set_d(1'b0, 1'b0, '0, '0, '0);
    tick();
    check_eq("d_rty_1cyc", DATA_W'(dmem_if.rty), '0);
    check_eq("d_rty_count", DATA_W'(d_rtys - base_b), DATA_W'(1));
    check_eq("d_rty_ack_count", DATA_W'(d_acks - base_a), '0);
    check_eq("d_rty_dat_hold", dmem_if.dat_s, {8{16'h0200}});
    mem_mode = M_ACK;
    set_i(1'b1, 12'h101);
    set_d(1'b1, 1'b0, 12'h201, '1, '0);
    first_winner("after_rty_winner", 0);

    // Simultaneous ack and rty: ack wins.
    mem_mode = M_BOTH;
    base_b   = i_rtys;
    set_i(1'b1, 12'h055);
    wait_pulse("both_ack", 1'b0, 1'b0, 10);
    set_i(1'b0, '0);
    tick();
    check_eq("both_no_rty", DATA_W'(i_rtys - base_b), '0);
    mem_mode = M_ACK;

    // Requester abandons mid-BUSY: memory still completes, no upstream pulse.
    mem_delay = 3;
    set_i(1'b1, 12'h077);
    tick();
    check_eq("drop_busy", DATA_W'(mem_if.cyc), DATA_W'(1));
    set_i(1'b0, '0);
    base_a = i_acks;
    base_b = i_rtys;
    base_c = mem_done;
    repeat (6) tick();
    check_eq("drop_no_ack", DATA_W'(i_acks - base_a), '0);
    check_eq("drop_no_rty", DATA_W'(i_rtys - base_b), '0);
    check_eq("drop_mem_done", DATA_W'(mem_done - base_c), DATA_W'(1));
    check_eq("drop_capture", imem_if.dat_s, {8{16'h0077}});
    mem_delay = 0;
    set_i(1'b1, 12'h102);
    set_d(1'b1, 1'b0, 12'h202, '1, '0);
    first_winner("after_drop_winner", 1);

    // Reset during BUSY abandons the memory cycle asynchronously.
    mem_mode = M_SILENT;
    set_i(1'b1, 12'h0AA);
    tick();
    tick();
    check_eq("rst_mid_busy", DATA_W'(mem_if.cyc), DATA_W'(1));
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_cyc", DATA_W'(mem_if.cyc), '0);
    check_eq("rst_mid_adr", DATA_W'(mem_if.adr), '0);
    check_eq("rst_mid_dat", imem_if.dat_s, '0);
    set_i(1'b0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_mode = M_ACK;
    set_i(1'b1, 12'h0AB);
    wait_pulse("post_rst_ack", 1'b0, 1'b0, 10);
    check_eq("post_rst_dat", imem_if.dat_s, {8{16'h00AB}});
    set_i(1'b0, '0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // Silent memory: watchdog retries after exactly TMO BUSY cycles.
    mem_mode = M_SILENT;
    base_b   = 0;
    set_i(1'b1, 12'h0CC);
    for (int c = 1; c < int'(TMO) + 1; c++) begin
      tick();
      if (imem_if.rty || !mem_if.cyc) base_b++;
    end
    check_eq("tmo_busy_hold", DATA_W'(base_b), '0);
    tick();
    check_eq("tmo_rty", DATA_W'(imem_if.rty), DATA_W'(1));
    check_eq("tmo_cyc_drop", DATA_W'(mem_if.cyc), '0);
    set_i(1'b0, '0);
    tick();
    check_eq("tmo_rty_1cyc", DATA_W'(imem_if.rty), '0);
    mem_mode = M_ACK;
`endif

    check_eq("no_overlap", DATA_W'(overlap), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
